seq_barrel_shifter: RTL and testbench
=====================================

# seq_barrel_shifter

Multi-cycle, parametrised shift/rotate unit for the processor datapath. It executes the six shifter modes (logical, arithmetic and rotate, each left and right) iteratively, moving up to STEP bit positions per clock under a start/done handshake. Relative to the single-cycle shifter it adds:
- a configurable width/area-versus-latency trade-off;
- a busy indication and a registered shift-out bit;
- arithmetic-left overflow detection and illegal-mode reporting.

It sits beside the ALU and is started by the control unit on OP_SHL/OP_SHR-class instructions.

## Interface
Parameters:
- REG_WIDTH, 32: operand/result width; power of two, ≥ 8.
- STEP, 1: bit positions shifted per SHIFT cycle; power of two, 1..REG_WIDTH.
- NB_W, $clog2(REG_WIDTH): width of nbits (derived).

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state immediately when low.
- start  in  1  request; sampled only in IDLE.
- op_a  in  REG_WIDTH  operand, latched on accepted start.
- nbits  in  NB_W  shift amount 0..REG_WIDTH-1, latched on accepted start.
- mode  in  3  000 SLL, 001 SRL, 010 SLA, 011 SRA, 100 ROL, 101 ROR; 110/111 illegal.
- result  out  REG_WIDTH  working/final value; valid while done=1, held until next accepted start.
- sout  out  1  last bit shifted/rotated past the boundary.
- ovf  out  1  SLA overflow (sticky within one operation).
- err  out  1  illegal mode on the current operation.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states IDLE, SHIFT, DONE. Reset → IDLE.
- IDLE, start=1:
  - latch op_a into result; latch mode; load rem=nbits; clear sout, ovf, err.
  - Illegal mode → DONE with err=1, result=op_a.
  - nbits=0 → DONE; result=op_a, sout=0.
  - Otherwise → SHIFT.
- SHIFT, each cycle:
  - s = min(STEP, rem); apply an s-bit shift in the latched mode; rem -= s.
  - rem reaches 0 → DONE.
- DONE: done=1 for this cycle only, then → IDLE. A start asserted during SHIFT or DONE is ignored (no queueing).
- Shift rules, n = latched nbits:
  - SLL/SLA: zero fill at LSB. Final sout = op_a[REG_WIDTH-n].
  - SLA only: ovf is set if any step changes result[MSB] relative to op_a[MSB].
  - SRL: zero fill. SRA: fill with op_a[MSB]. For both, final sout = op_a[n-1].
  - ROL: bits leaving the MSB enter the LSB; final sout = final result[0].
  - ROR: bits leaving the LSB enter the MSB; final sout = final result[MSB].
- Final result equals the single-cycle equivalent for every mode and n in 0..REG_WIDTH-1, independent of STEP.
- ovf and err are 0 for all modes other than SLA and the illegal modes respectively.

## Timing
- Reset (reset=0, asynchronous): state=IDLE; result=0, sout=0, ovf=0, err=0, done=0, busy=0; rem cleared.
- Reset mid-SHIFT or mid-DONE aborts the operation; done is never asserted for the aborted operation.
- Start accepted at edge 0. k = ceil(n/STEP) SHIFT cycles follow; done=1 in cycle k+1. Total latency k+1 cycles.
- Latency for n=0 or an illegal mode: done in cycle 1.
- busy rises the cycle after the accepted start and falls the cycle after done.
- Earliest next accepted start is the edge at which busy is low, i.e. back-to-back with one idle cycle.
- result/sout/ovf/err are stable from the done cycle until the next accepted start. result may change every SHIFT cycle.
- Changes on op_a/nbits/mode after acceptance have no effect.

## Test plan
- REG_WIDTH=32, STEP=1, SRA, op_a=0x8000_00F0, n=4 → result=0xF800_000F, sout=0, ovf=0, done in cycle 5, busy high cycles 1–5.
- STEP=1, ROL, op_a=0x8000_0001, n=1 → result=0x0000_0003, sout=1, done in cycle 2. Then SLA, op_a=0x4000_0000, n=1 → result=0x8000_0000, ovf=1, sout=0.
- STEP=4, SLL, op_a=0x1234_5678, n=28 → k=7, result=0x8000_0000, sout=1, done in cycle 8. Repeat with STEP=1 (done in cycle 29) → identical result/sout.
- mode=110, op_a=0xDEAD_BEEF, n=5 → err=1, result=0xDEAD_BEEF, done in cycle 1. Then SRL with n=0 → result=op_a, sout=0, err=0, done in cycle 1.
- Start pulsed during SHIFT and in the DONE cycle → ignored: result unchanged, only one done pulse. The next start is accepted only once busy=0.
- reset driven low in SHIFT cycle 3 of an n=20 SRL → all outputs 0 immediately, no done pulse. After release, a new SRL n=2 on 0x0000_000C → result=0x0000_0003, sout=0, done in cycle 3.

Source files
------------

// File: rtl/seq_barrel_shifter.sv
// Multi-cycle shift/rotate unit: moves up to STEP bit positions per clock
// in one of six modes under a start/done handshake, with SLA overflow and illegal-mode flags.
module seq_barrel_shifter #(
   parameter int REG_WIDTH = 32,
   parameter int STEP      = 1,
   parameter int NB_W      = $clog2(REG_WIDTH)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [REG_WIDTH-1:0] op_a,
   input  logic [NB_W-1:0]      nbits,
   input  logic [2:0]           mode,
   output logic [REG_WIDTH-1:0] result,
   output logic                 sout,
   output logic                 ovf,
   output logic                 err,
   output logic                 done,
   output logic                 busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [2:0] MODE_SLL = 3'b000;
   localparam logic [2:0] MODE_SRL = 3'b001;
   localparam logic [2:0] MODE_SLA = 3'b010;
   localparam logic [2:0] MODE_SRA = 3'b011;
   localparam logic [2:0] MODE_ROL = 3'b100;
   localparam logic [2:0] MODE_ROR = 3'b101;

   localparam logic [NB_W:0] STEP_W  = (NB_W+1)'(STEP);
   localparam logic [NB_W:0] WIDTH_W = (NB_W+1)'(REG_WIDTH);

   logic [1:0]           state;
   logic [NB_W-1:0]      rem;
   logic [2:0]           mode_r;
   logic                 msb_r;

   logic [NB_W:0]        step_amt;
   logic [NB_W:0]        inv_amt;
   logic [NB_W-1:0]      rem_next;
   logic [REG_WIDTH-1:0] shl, shr, sra, out_hi, out_lo, msb_diff;
   logic [REG_WIDTH-1:0] next_result;
   logic                 next_sout;
   logic                 ovf_step;

   always_comb begin
      step_amt = ({1'b0, rem} < STEP_W) ? {1'b0, rem} : STEP_W;
      inv_amt  = WIDTH_W - step_amt;
      rem_next = rem - step_amt[NB_W-1:0];
      shl      = result << step_amt;
      shr      = result >> step_amt;
      sra      = $signed(result) >>> step_amt;
      // bit 0 of out_hi is the last bit leaving the MSB side, of out_lo the last leaving the LSB side
      out_hi   = result >> inv_amt;
      out_lo   = result >> (step_amt - 1'b1);
      // every bit passing through the MSB this step is compared with the original sign
      msb_diff = {result[REG_WIDTH-2:0], 1'b0} ^ {REG_WIDTH{msb_r}};
      ovf_step = |(msb_diff >> inv_amt);

      next_result = result;
      next_sout   = sout;
      case (mode_r)
         MODE_SLL, MODE_SLA: begin
            next_result = shl;
            next_sout   = out_hi[0];
         end
         MODE_SRL: begin
            next_result = shr;
            next_sout   = out_lo[0];
         end
         MODE_SRA: begin
            next_result = sra;
            next_sout   = out_lo[0];
         end
         MODE_ROL: begin
            next_result = shl | out_hi;
            next_sout   = out_hi[0];
         end
         MODE_ROR: begin
            next_result = shr | (result << inv_amt);
            next_sout   = out_lo[0];
         end
         default: begin
            next_result = result;
            next_sout   = sout;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         result <= '0;
         rem    <= '0;
         mode_r <= '0;
         msb_r  <= 1'b0;
         sout   <= 1'b0;
         ovf    <= 1'b0;
         err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  result <= op_a;
                  mode_r <= mode;
                  msb_r  <= op_a[REG_WIDTH-1];
                  rem    <= nbits;
                  sout   <= 1'b0;
                  ovf    <= 1'b0;
                  err    <= 1'b0;
                  if (mode[2] && mode[1]) begin
                     err   <= 1'b1;
                     state <= DONE;
                  end else if (nbits == '0) begin
                     state <= DONE;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               result <= next_result;
               sout   <= next_sout;
               rem    <= rem_next;
               if (mode_r == MODE_SLA && ovf_step) ovf <= 1'b1;
               if (rem_next == '0) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign done = (state == DONE);
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_seq_barrel_shifter.sv
// Randomized bench for seq_barrel_shifter: STEP=1 and STEP=4 instances share stimulus
// and are compared against an arithmetic reference model.
module tb_seq_barrel_shifter;

   localparam int W = 32;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [W-1:0]  op_a  = '0;
   logic [4:0]    nbits = '0;
   logic [2:0]    mode  = '0;

   logic [W-1:0]  res1, res4;
   logic          sout1, ovf1, err1, done1, busy1;
   logic          sout4, ovf4, err4, done4, busy4;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   seq_barrel_shifter #(.REG_WIDTH(W), .STEP(1)) u_step1 (
      .clock(clock), .reset(reset), .start(start), .op_a(op_a), .nbits(nbits), .mode(mode),
      .result(res1), .sout(sout1), .ovf(ovf1), .err(err1), .done(done1), .busy(busy1));

   seq_barrel_shifter #(.REG_WIDTH(W), .STEP(4)) u_step4 (
      .clock(clock), .reset(reset), .start(start), .op_a(op_a), .nbits(nbits), .mode(mode),
      .result(res4), .sout(sout4), .ovf(ovf4), .err(err4), .done(done4), .busy(busy4));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model(input logic [W-1:0] a, input int n, input logic [2:0] m,
                        output logic [W-1:0] r, output logic s, output logic o, output logic e);
      logic [2*W-1:0] w;
      logic [W-1:0]   top;
      r = a; s = 1'b0; o = 1'b0; e = 1'b0;
      if (m >= 3'd6) e = 1'b1;
      else if (n != 0) begin
         case (m)
            3'd0, 3'd2: begin
               r = a << n;
               s = a[W-n];
               if (m == 3'd2) begin
                  top = a >> (W - 1 - n);
                  o = !(top == 0 || top == ((32'h1 << (n + 1)) - 1));
               end
            end
            3'd1: begin r = a >> n; s = a[n-1]; end
            3'd3: begin
               r = (a >> n) | (a[W-1] ? ~(32'hFFFF_FFFF >> n) : 32'h0);
               s = a[n-1];
            end
            3'd4: begin w = {a, a} << n; r = w[2*W-1:W]; s = r[0]; end
            default: begin w = {a, a} >> n; r = w[W-1:0]; s = r[W-1]; end
         endcase
      end
   endtask

   function automatic int exp_lat(input int n, input logic [2:0] m, input int step);
      if (m >= 3'd6 || n == 0) return 1;
      return (n + step - 1) / step + 1;
   endfunction

   task automatic do_op(input logic [W-1:0] a, input int n, input logic [2:0] m, input bit spam);
      logic [W-1:0] er, r1, r4;
      logic es, eo, ee, s1, s4, o1, o4, e1, e4;
      int el1, el4, lf, got1, got4, p1, p4;
      bit seen1, seen4;
      model(a, n, m, er, es, eo, ee);
      el1 = exp_lat(n, m, 1);
      el4 = exp_lat(n, m, 4);
      lf  = (el1 < el4) ? el1 : el4;
      got1 = 0; got4 = 0; p1 = 0; p4 = 0; seen1 = 0; seen4 = 0;
      r1 = '0; r4 = '0; s1 = 0; s4 = 0; o1 = 0; o4 = 0; e1 = 0; e4 = 0;
      @(negedge clock);
      op_a = a; nbits = 5'(n); mode = m; start = 1'b1;
      @(posedge clock);
      #1;
      op_a = $urandom; nbits = 5'($urandom); mode = 3'($urandom);
      start = spam;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clock);
         if (done1) begin
            p1++;
            if (!seen1) begin seen1 = 1; got1 = c; r1 = res1; s1 = sout1; o1 = ovf1; e1 = err1; end
         end
         if (done4) begin
            p4++;
            if (!seen4) begin seen4 = 1; got4 = c; r4 = res4; s4 = sout4; o4 = ovf4; e4 = err4; end
         end
         check("busy1", 64'(busy1), 64'(c <= el1));
         check("busy4", 64'(busy4), 64'(c <= el4));
         if (spam && c >= lf) start = 1'b0;
         if (seen1 && seen4 && c > got1 && c > got4) break;
      end
      start = 1'b0;
      check("lat1", 64'(got1), 64'(el1));
      check("lat4", 64'(got4), 64'(el4));
      check("pulses1", 64'(p1), 64'd1);
      check("pulses4", 64'(p4), 64'd1);
      check("result1", 64'(r1), 64'(er));
      check("result4", 64'(r4), 64'(er));
      check("sout1", 64'(s1), 64'(es));
      check("sout4", 64'(s4), 64'(es));
      check("ovf1", 64'(o1), 64'(eo));
      check("ovf4", 64'(o4), 64'(eo));
      check("err1", 64'(e1), 64'(ee));
      check("err4", 64'(e4), 64'(ee));
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_res1"}, 64'(res1), 64'd0);
      check({tag, "_res4"}, 64'(res4), 64'd0);
      check({tag, "_flags1"}, 64'({sout1, ovf1, err1, done1, busy1}), 64'd0);
      check({tag, "_flags4"}, 64'({sout4, ovf4, err4, done4, busy4}), 64'd0);
   endtask

   initial begin
      repeat (3) @(negedge clock);
      check_cleared("reset");
      reset = 1'b1;

      do_op(32'h8000_00F0, 4,  3'b011, 0);
      do_op(32'h8000_0001, 1,  3'b100, 0);
      do_op(32'h4000_0000, 1,  3'b010, 0);
      do_op(32'h1234_5678, 28, 3'b000, 0);
      do_op(32'hDEAD_BEEF, 5,  3'b110, 0);
      do_op(32'hDEAD_BEEF, 0,  3'b001, 0);
      do_op(32'hA5A5_0F0F, 13, 3'b101, 1);
      do_op(32'h7FFF_FFFF, 31, 3'b010, 1);
      do_op(32'hFFFF_FFFF, 31, 3'b010, 0);

      for (int i = 0; i < 80; i++)
         do_op($urandom, int'($urandom_range(0, W - 1)), 3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));

      // abort an SRL n=20 in its third SHIFT cycle
      @(negedge clock);
      op_a = $urandom; nbits = 5'd20; mode = 3'b001; start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      #1 check_cleared("abort");
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         check("abort_done", 64'({done1, done4}), 64'd0);
      end
      reset = 1'b1;
      do_op(32'h0000_000C, 2, 3'b001, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
